// File: rtl/compare_result_pkg.sv
// Shared definitions for the comparator result tracker:
// result code constants, FSM state encoding, code legality check.
package compare_result_pkg;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [2:0] r);
    return (r != 3'b000) && ((r & (r - 3'd1)) == 3'b000);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async reset.
// Ports: clk, rst (async, high), clr, inc, count (W bits).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/compare_result_tracker.sv
// Debounces 3-bit comparator result codes: per-outcome saturating
// tallies, decision lock after STABLE_N identical codes, sticky
// illegal-code error. Ports: clk, rst (async, high), R_valid, R,
// clear -> gt/eq/lt_count, decision, decision_valid, code_error.
module compare_result_tracker
  import compare_result_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int STABLE_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             R_valid,
  input  logic [2:0]       R,
  input  logic             clear,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [2:0]       decision,
  output logic             decision_valid,
  output logic             code_error
);

  localparam int RUN_W = $clog2(STABLE_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       dec_q, dec_d;
  logic             inc_gt, inc_eq, inc_lt;
  logic             take;

  // A sample is considered only outside ERR and when not cleared.
  assign take = R_valid && !clear && (state_q != ST_ERR);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = prev_q;
    dec_d   = dec_q;
    inc_gt  = 1'b0;
    inc_eq  = 1'b0;
    inc_lt  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      run_d   = '0;
      prev_d  = '0;
      dec_d   = '0;
    end else if (take) begin
      if (!is_legal(R)) begin
        state_d = ST_ERR;
      end else begin
        unique case (1'b1)
          R[2]: inc_gt = 1'b1;
          R[1]: inc_eq = 1'b1;
          R[0]: inc_lt = 1'b1;
          default: ;
        endcase
        if ((state_q == ST_IDLE) || (R != prev_q)) begin
          // New run starts; a threshold of one locks at once.
          run_d  = RUN_ONE;
          prev_d = R;
          if (RUN_MAX == RUN_ONE) begin
            state_d = ST_LOCKED;
            dec_d   = R;
          end else begin
            state_d = ST_TRACK;
          end
        end else begin
          if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_ONE;
          end
          if (run_d == RUN_MAX) begin
            state_d = ST_LOCKED;
            dec_d   = R;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      prev_q  <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      dec_q   <= dec_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_gt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (inc_gt),
    .count (gt_count)
  );

  sat_counter #(.W(CNT_W)) u_eq (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (inc_eq),
    .count (eq_count)
  );

  sat_counter #(.W(CNT_W)) u_lt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (inc_lt),
    .count (lt_count)
  );

  assign decision       = dec_q;
  assign decision_valid = (state_q == ST_LOCKED);
  assign code_error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_compare_result_tracker.sv
// Directed bench for compare_result_tracker: main instance
// (CNT_W=8, STABLE_N=3) plus a narrow one (CNT_W=2, STABLE_N=1).
module tb_compare_result_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       R_valid = 1'b0;
  logic [2:0] R = 3'b000;
  logic       clear = 1'b0;

  logic [7:0] gt1, eq1, lt1;
  logic [2:0] dec1;
  logic       dv1, err1;
  logic [1:0] gt2, eq2, lt2;
  logic [2:0] dec2;
  logic       dv2, err2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  compare_result_tracker #(.CNT_W(8), .STABLE_N(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .R_valid        (R_valid),
    .R              (R),
    .clear          (clear),
    .gt_count       (gt1),
    .eq_count       (eq1),
    .lt_count       (lt1),
    .decision       (dec1),
    .decision_valid (dv1),
    .code_error     (err1)
  );

  compare_result_tracker #(.CNT_W(2), .STABLE_N(1)) dut_n (
    .clk            (clk),
    .rst            (rst),
    .R_valid        (R_valid),
    .R              (R),
    .clear          (clear),
    .gt_count       (gt2),
    .eq_count       (eq2),
    .lt_count       (lt2),
    .decision       (dec2),
    .decision_valid (dv2),
    .code_error     (err2)
  );

  task automatic step(input logic v, input logic [2:0] r,
                      input logic c);
    @(negedge clk);
    R_valid = v;
    R       = r;
    clear   = c;
    @(posedge clk);
    #1;
    R_valid = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({gt1, eq1, lt1, dec1, dv1, err1} !== 29'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0",
               {gt1, eq1, lt1, dec1, dv1, err1});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_gt();
    step(1, 3'b100, 0);
    step(1, 3'b100, 0);
    checks++;
    if (dv1 !== 1'b0) begin
      errors++;
      $display("FAIL lock_gt_early dv=%b exp=0", dv1);
    end
    step(1, 3'b100, 0);
    checks++;
    if ({dv1, dec1, gt1, eq1, lt1} !== {1'b1, 3'b100, 8'd3, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL lock_gt dv=%b dec=%b gt=%0d eq=%0d lt=%0d exp 1 100 3 0 0",
               dv1, dec1, gt1, eq1, lt1);
    end
  endtask

  task automatic test_run_break();
    step(0, 3'b000, 1);
    step(1, 3'b100, 0);
    step(1, 3'b100, 0);
    step(1, 3'b010, 0);
    checks++;
    if ({dv1, dec1, gt1, eq1} !== {1'b0, 3'b000, 8'd2, 8'd1}) begin
      errors++;
      $display("FAIL run_break dv=%b dec=%b gt=%0d eq=%0d exp 0 000 2 1",
               dv1, dec1, gt1, eq1);
    end
    step(1, 3'b010, 0);
    checks++;
    if (dv1 !== 1'b0) begin
      errors++;
      $display("FAIL run_break_mid dv=%b exp=0", dv1);
    end
    step(1, 3'b010, 0);
    checks++;
    if ({dv1, dec1, eq1} !== {1'b1, 3'b010, 8'd3}) begin
      errors++;
      $display("FAIL relock_eq dv=%b dec=%b eq=%0d exp 1 010 3",
               dv1, dec1, eq1);
    end
    step(1, 3'b001, 0);
    checks++;
    if ({dv1, dec1, lt1} !== {1'b0, 3'b010, 8'd1}) begin
      errors++;
      $display("FAIL unlock_keep dv=%b dec=%b lt=%0d exp 0 010 1",
               dv1, dec1, lt1);
    end
  endtask

  task automatic test_illegal();
    step(1, 3'b011, 0);
    checks++;
    if ({err1, gt1, eq1, lt1} !== {1'b1, 8'd2, 8'd3, 8'd1}) begin
      errors++;
      $display("FAIL illegal err=%b gt=%0d eq=%0d lt=%0d exp 1 2 3 1",
               err1, gt1, eq1, lt1);
    end
    for (int i = 0; i < 5; i++) step(1, 3'b001, 0);
    checks++;
    if ({err1, dv1, lt1} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL err_ignore err=%b dv=%b lt=%0d exp 1 0 1",
               err1, dv1, lt1);
    end
    step(0, 3'b000, 1);
    checks++;
    if ({gt1, eq1, lt1, dec1, dv1, err1} !== 29'd0) begin
      errors++;
      $display("FAIL clear_all got=%h exp=0",
               {gt1, eq1, lt1, dec1, dv1, err1});
    end
  endtask

  task automatic test_saturation();
    step(0, 3'b000, 1);
    step(1, 3'b001, 0);
    checks++;
    if ({dv2, dec2, lt2} !== {1'b1, 3'b001, 2'd1}) begin
      errors++;
      $display("FAIL n1_lock dv=%b dec=%b lt=%0d exp 1 001 1",
               dv2, dec2, lt2);
    end
    for (int i = 0; i < 5; i++) step(1, 3'b001, 0);
    checks++;
    if (lt2 !== 2'd3) begin
      errors++;
      $display("FAIL sat_lt got=%0d exp=3", lt2);
    end
    checks++;
    if ({lt1, dv1, dec1} !== {8'd6, 1'b1, 3'b001}) begin
      errors++;
      $display("FAIL wide_lt lt=%0d dv=%b dec=%b exp 6 1 001",
               lt1, dv1, dec1);
    end
    step(1, 3'b100, 0);
    checks++;
    if ({dv2, dec2, gt2, lt2} !== {1'b1, 3'b100, 2'd1, 2'd3}) begin
      errors++;
      $display("FAIL n1_switch dv=%b dec=%b gt=%0d lt=%0d exp 1 100 1 3",
               dv2, dec2, gt2, lt2);
    end
  endtask

  task automatic test_gap();
    step(0, 3'b000, 1);
    step(1, 3'b100, 0);
    for (int i = 0; i < 4; i++) step(0, 3'b010, 0);
    step(1, 3'b100, 0);
    checks++;
    if ({dv1, gt1, eq1} !== {1'b0, 8'd2, 8'd0}) begin
      errors++;
      $display("FAIL gap_mid dv=%b gt=%0d eq=%0d exp 0 2 0",
               dv1, gt1, eq1);
    end
    step(1, 3'b100, 0);
    checks++;
    if ({dv1, dec1, gt1} !== {1'b1, 3'b100, 8'd3}) begin
      errors++;
      $display("FAIL gap_lock dv=%b dec=%b gt=%0d exp 1 100 3",
               dv1, dec1, gt1);
    end
  endtask

  task automatic test_clear_priority();
    step(1, 3'b100, 1);
    checks++;
    if ({gt1, eq1, lt1, dec1, dv1, err1} !== 29'd0) begin
      errors++;
      $display("FAIL clear_prio got=%h exp=0",
               {gt1, eq1, lt1, dec1, dv1, err1});
    end
  endtask

  task automatic test_async_reset();
    step(1, 3'b100, 0);
    step(1, 3'b100, 0);
    step(1, 3'b100, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gt1, eq1, lt1, dec1, dv1, err1} !== 29'd0) begin
      errors++;
      $display("FAIL async_rst got=%h exp=0",
               {gt1, eq1, lt1, dec1, dv1, err1});
    end
    #1;
    rst = 1'b0;
    step(1, 3'b010, 0);
    checks++;
    if ({eq1, gt1, dv1} !== {8'd1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL post_rst eq=%0d gt=%0d dv=%b exp 1 0 0",
               eq1, gt1, dv1);
    end
  endtask

  initial begin
    test_reset();
    test_lock_gt();
    test_run_break();
    test_illegal();
    test_saturation();
    test_gap();
    test_clear_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
